// File: rtl/am2910_seq_core.sv
// Am2910-style next-address core: decodes the microinstruction, selects Y,
// maintains uPC and the register/counter R, and drives the external LIFO strobes.
module am2910_seq_core #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       instr,
  input  logic             cc_n,
  input  logic             ccen_n,
  input  logic             ci,
  input  logic             rld_n,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] stack_top,
  input  logic             stack_full,
  input  logic             stack_empty,
  output logic             push_en,
  output logic             pop_en,
  output logic             clear_en,
  output logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] y,
  output logic             full_n,
  output logic             pl_n,
  output logic             map_n,
  output logic             vect_n
);

  localparam logic [3:0] OP_JZ   = 4'd0;
  localparam logic [3:0] OP_CJS  = 4'd1;
  localparam logic [3:0] OP_JMAP = 4'd2;
  localparam logic [3:0] OP_CJP  = 4'd3;
  localparam logic [3:0] OP_PUSH = 4'd4;
  localparam logic [3:0] OP_JSRP = 4'd5;
  localparam logic [3:0] OP_CJV  = 4'd6;
  localparam logic [3:0] OP_JRP  = 4'd7;
  localparam logic [3:0] OP_RFCT = 4'd8;
  localparam logic [3:0] OP_RPCT = 4'd9;
  localparam logic [3:0] OP_CRTN = 4'd10;
  localparam logic [3:0] OP_CJPP = 4'd11;
  localparam logic [3:0] OP_LDCT = 4'd12;
  localparam logic [3:0] OP_LOOP = 4'd13;
  localparam logic [3:0] OP_CONT = 4'd14;
  localparam logic [3:0] OP_TWB  = 4'd15;

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

  logic [WIDTH-1:0] upc_r;
  logic [WIDTH-1:0] r_r;

  logic             pass_s;
  logic             rz_s;
  logic [WIDTH-1:0] y_s;
  logic             push_s;
  logic             pop_s;
  logic             clear_s;
  logic             r_load_s;
  logic             r_dec_s;
  logic             pl_n_s;
  logic             map_n_s;
  logic             vect_n_s;

  // Empty flag is informational only; underflow handling lives in the stack block.
  logic             unused_flags;
  assign unused_flags = stack_empty;

  assign pass_s = ccen_n | ~cc_n;
  assign rz_s   = (r_r == ZERO_W);

  // Next-address select, stack strobes and R load/decrement requests.
  always_comb begin
    y_s      = upc_r;
    push_s   = 1'b0;
    pop_s    = 1'b0;
    clear_s  = 1'b0;
    r_load_s = 1'b0;
    r_dec_s  = 1'b0;
    case (instr)
      OP_JZ: begin
        y_s     = ZERO_W;
        clear_s = 1'b1;
      end
      OP_CJS: begin
        if (pass_s) begin
          y_s    = d;
          push_s = 1'b1;
        end else begin
          y_s = upc_r;
        end
      end
      OP_JMAP: y_s = d;
      OP_CJP: begin
        if (pass_s) y_s = d;
        else        y_s = upc_r;
      end
      OP_PUSH: begin
        push_s   = 1'b1;
        y_s      = upc_r;
        r_load_s = pass_s;
      end
      OP_JSRP: begin
        push_s = 1'b1;
        if (pass_s) y_s = d;
        else        y_s = r_r;
      end
      OP_CJV: begin
        if (pass_s) y_s = d;
        else        y_s = upc_r;
      end
      OP_JRP: begin
        if (pass_s) y_s = d;
        else        y_s = r_r;
      end
      OP_RFCT: begin
        if (!rz_s) begin
          y_s     = stack_top;
          r_dec_s = 1'b1;
        end else begin
          y_s   = upc_r;
          pop_s = 1'b1;
        end
      end
      OP_RPCT: begin
        if (!rz_s) begin
          y_s     = d;
          r_dec_s = 1'b1;
        end else begin
          y_s = upc_r;
        end
      end
      OP_CRTN: begin
        if (pass_s) begin
          y_s   = stack_top;
          pop_s = 1'b1;
        end else begin
          y_s = upc_r;
        end
      end
      OP_CJPP: begin
        if (pass_s) begin
          y_s   = d;
          pop_s = 1'b1;
        end else begin
          y_s = upc_r;
        end
      end
      OP_LDCT: begin
        y_s      = upc_r;
        r_load_s = 1'b1;
      end
      OP_LOOP: begin
        if (pass_s) begin
          y_s   = upc_r;
          pop_s = 1'b1;
        end else begin
          y_s = stack_top;
        end
      end
      OP_CONT: y_s = upc_r;
      OP_TWB: begin
        if (!rz_s) begin
          r_dec_s = 1'b1;
          if (pass_s) begin
            y_s   = upc_r;
            pop_s = 1'b1;
          end else begin
            y_s = stack_top;
          end
        end else begin
          pop_s = 1'b1;
          if (pass_s) y_s = upc_r;
          else        y_s = d;
        end
      end
      default: y_s = upc_r;
    endcase
  end

  // One-hot-low enable for the pipeline register, mapping PROM or vector source.
  always_comb begin
    pl_n_s   = 1'b0;
    map_n_s  = 1'b1;
    vect_n_s = 1'b1;
    case (instr)
      OP_JMAP: begin
        pl_n_s  = 1'b1;
        map_n_s = 1'b0;
      end
      OP_CJV: begin
        pl_n_s   = 1'b1;
        vect_n_s = 1'b0;
      end
      default: begin
        pl_n_s   = 1'b0;
        map_n_s  = 1'b1;
        vect_n_s = 1'b1;
      end
    endcase
  end

  // While reset is held, present a quiet, deterministic interface.
  always_comb begin
    if (!reset_n) begin
      y        = ZERO_W;
      push_en  = 1'b0;
      pop_en   = 1'b0;
      clear_en = 1'b0;
      pl_n     = 1'b0;
      map_n    = 1'b1;
      vect_n   = 1'b1;
    end else begin
      y        = y_s;
      push_en  = push_s;
      pop_en   = pop_s;
      clear_en = clear_s;
      pl_n     = pl_n_s;
      map_n    = map_n_s;
      vect_n   = vect_n_s;
    end
  end

  assign push_data = upc_r;
  assign full_n    = ~stack_full;

  // uPC follows Y plus carry-in; R takes an external load over any instruction action.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      upc_r <= ZERO_W;
      r_r   <= ZERO_W;
    end else begin
      upc_r <= y_s + {{(WIDTH-1){1'b0}}, ci};
      if (!rld_n) begin
        r_r <= d;
      end else if (r_load_s) begin
        r_r <= d;
      end else if (r_dec_s) begin
        r_r <= r_r - {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
        r_r <= r_r;
      end
    end
  end

endmodule

// File: doc/am2910_seq_core.md
Name: am2910_seq_core

Overview:
- Next-address control core of the Am2910-style microprogram sequencer; sits directly upstream of the 12-bit LIFO stack block and drives its push_en/pop_en/clear_en/data_in.
- Consumes the stack's data_out/full/empty.
- Decodes the 4-bit microinstruction and condition inputs, then selects next address Y from D, register/counter R, uPC, stack top or zero.
- Maintains the uPC and R registers.

Parameters:
- WIDTH, 12, width of addresses, D, R, uPC and stack data.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  synchronous active-low reset.
- instr  input  4  microinstruction code, 0..15.
- cc_n  input  1  condition code, active low.
- ccen_n  input  1  condition enable, active low; high forces pass.
- ci  input  1  uPC increment carry-in.
- rld_n  input  1  R load strobe, active low.
- d  input  WIDTH  direct/branch input.
- stack_top  input  WIDTH  stack data_out.
- stack_full  input  1  stack full flag.
- stack_empty  input  1  stack empty flag.
- push_en  output  1  stack push request.
- pop_en  output  1  stack pop request.
- clear_en  output  1  stack clear request.
- push_data  output  WIDTH  value pushed; always current uPC.
- y  output  WIDTH  next microaddress; combinational.
- full_n  output  1  equals ~stack_full.
- pl_n  output  1  pipeline-register enable, active low.
- map_n  output  1  mapping PROM enable, active low.
- vect_n  output  1  vector enable, active low.

Behaviour:
- Reset: one clock; reset is synchronous and active-low (reset_n); polarity and synchronicity are fixed. Rising edge with reset_n=0 sets uPC=0 and R=0. While reset_n=0, outputs are forced: y=0, push_en=0, pop_en=0, clear_en=0, pl_n=0, map_n=1, vect_n=1.
- Pass: pass = ccen_n | ~cc_n. Fail = ~pass. Rz means R==0.
- Enables: exactly one of pl_n/map_n/vect_n is low.
  - map_n low for JMAP.
  - vect_n low for CJV.
  - pl_n low for all other codes.
- Decode table; y is combinational, and stack strobes are combinational for the same cycle:
  - 0 JZ: y=0; clear_en=1.
  - 1 CJS: pass → y=d, push. Fail → y=uPC.
  - 2 JMAP: y=d.
  - 3 CJP: pass → d. Fail → uPC.
  - 4 PUSH: push always; y=uPC; pass → R<=d.
  - 5 JSRP: push always; pass → y=d. Fail → y=R.
  - 6 CJV: pass → d. Fail → uPC.
  - 7 JRP: pass → d. Fail → R.
  - 8 RFCT: !Rz → y=stack_top, R<=R-1. Rz → y=uPC, pop.
  - 9 RPCT: !Rz → y=d, R<=R-1. Rz → y=uPC.
  - 10 CRTN: pass → y=stack_top, pop. Fail → uPC.
  - 11 CJPP: pass → y=d, pop. Fail → uPC.
  - 12 LDCT: R<=d; y=uPC.
  - 13 LOOP: pass → y=uPC, pop. Fail → y=stack_top.
  - 14 CONT: y=uPC.
  - 15 TWB:
    - !Rz & fail → y=stack_top, R<=R-1.
    - !Rz & pass → y=uPC, pop, R<=R-1.
    - Rz & fail → y=d, pop.
    - Rz & pass → y=uPC, pop.
- uPC: every non-reset edge, uPC <= y + ci, modulo 2^WIDTH. 0xFFF + 1 wraps to 0x000.
- R priority, highest first:
  1. reset.
  2. rld_n=0 → R<=d. Overrides any instruction load or decrement.
  3. Instruction load (PUSH pass, LDCT).
  4. Decrement.
  5. Hold.
- Decrement wrap: never occurs, because decrement is gated by !Rz.
- push_data: always equals the registered uPC (pre-update value).
- Stack flag independence: push_en and pop_en are never asserted together. Both are asserted regardless of stack_full/stack_empty; overflow and underflow handling belongs to the stack block.
- full_n: mirrors ~stack_full combinationally.
- Mid-operation reset: a reset mid-loop discards R and uPC in the same edge. No pending state survives.

Test Plan:
- Reset, then CONT with ci=1 for 4 cycles → y = 0,1,2,3; push_en/pop_en stay 0.
- uPC=0x010, CJS, ccen_n=0, cc_n=0, d=0x2A0 → y=0x2A0, push_en=1, push_data=0x010. Next cycle uPC=0x2A1. Then CRTN pass with stack_top=0x010 → y=0x010, pop_en=1.
- LDCT d=0x003, then RPCT d=0x100 for 4 cycles → y=0x100 ×3 with R 3→2→1→0, then y=uPC with R=0.
- PUSH with pass and d=0x002 (uPC=0x050), then RFCT with stack_top=0x050 → y=0x050 twice, then y=uPC with pop_en=1.
- JZ → y=0, clear_en=1. JMAP → map_n=0, pl_n=1. CJV → vect_n=0. CJP with fail (ccen_n=0, cc_n=1) → y=uPC.
- rld_n=0, d=0x7FF during RFCT decrement → R=0x7FF next cycle. Reset asserted mid-loop → uPC=0, R=0, y=0.
